// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual selection and an automatic scan
// mode that steps through every channel with a programmable dwell time.
module mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [DWELL_W-1:0]        dwell,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic                      valid,
  output logic                      wrap
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t             state;
  logic [SEL_W-1:0]   scan_idx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [SEL_W-1:0]   idx_inc;
  logic               advance;

  always_comb begin
    advance = (dwell_cnt == dwell);
    idx_inc = (int'(scan_idx) == CHANNELS - 1) ? '0 : scan_idx + 1'b1;
  end

  // scan_idx is the channel currently on data_out; dwell_cnt counts how many
  // further cycles it has been shown, so entry shows channel 0 for dwell+1 cycles.
  // NOTE: all state and outputs use non-blocking assignments so every branch
  // reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      scan_idx  <= '0;
      dwell_cnt <= '0;
      data_out  <= '0;
      chan_out  <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (!mode) begin
      state    <= MANUAL;
      chan_out <= sel;
      wrap     <= 1'b0;
      if (int'(sel) < CHANNELS) begin
        data_out <= data_in[int'(sel)*WIDTH +: WIDTH];
        valid    <= 1'b1;
      end else begin
        data_out <= '0;
        valid    <= 1'b0;
      end
    end else if (state != SCAN) begin
      state     <= SCAN;
      scan_idx  <= '0;
      dwell_cnt <= '0;
      data_out  <= data_in[WIDTH-1:0];
      chan_out  <= '0;
      valid     <= 1'b1;
      wrap      <= 1'b0;
    end else if (advance) begin
      scan_idx  <= idx_inc;
      dwell_cnt <= '0;
      data_out  <= data_in[int'(idx_inc)*WIDTH +: WIDTH];
      chan_out  <= idx_inc;
      valid     <= 1'b1;
      wrap      <= (idx_inc == '0);
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
      data_out  <= data_in[int'(scan_idx)*WIDTH +: WIDTH];
      chan_out  <= scan_idx;
      valid     <= 1'b1;
      wrap      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: a 4-channel instance for the main function and
// a 3-channel instance sharing the controls for the out-of-range index case.
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in4;
  logic [11:0] data_in3;
  logic        enable;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  dwell;

  logic [3:0]  data_out4, data_out3;
  logic [1:0]  chan_out4, chan_out3;
  logic        valid4, valid3, wrap4, wrap3;

  int checks   = 0;
  int failures = 0;

  logic [3:0] chan_val [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

  always #5 clk = ~clk;

  mux_scan #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL_W(4)) dut4 (
    .clk(clk), .reset(reset), .data_in(data_in4), .enable(enable),
    .mode(mode), .sel(sel), .dwell(dwell),
    .data_out(data_out4), .chan_out(chan_out4), .valid(valid4), .wrap(wrap4)
  );

  mux_scan #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL_W(4)) dut3 (
    .clk(clk), .reset(reset), .data_in(data_in3), .enable(enable),
    .mode(mode), .sel(sel), .dwell(dwell),
    .data_out(data_out3), .chan_out(chan_out3), .valid(valid3), .wrap(wrap3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] d, input logic [1:0] c,
                        input logic v, input logic w);
    check({tag, ".data"},  32'(data_out4), 32'(d));
    check({tag, ".chan"},  32'(chan_out4), 32'(c));
    check({tag, ".valid"}, 32'(valid4),    32'(v));
    check({tag, ".wrap"},  32'(wrap4),     32'(w));
  endtask

  initial begin
    data_in4 = 16'hDCBA;
    data_in3 = 12'hCBA;
    reset = 1'b1; enable = 1'b1; mode = 1'b1; sel = '0; dwell = 4'd2;
    #1;

    for (int i = 0; i < 2; i++) begin
      step();
      check4($sformatf("reset%0d", i), 4'h0, 2'd0, 1'b0, 1'b0);
    end

    reset = 1'b0; mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
      check4($sformatf("manual_sel%0d", s), chan_val[s], 2'(s), 1'b1, 1'b0);
      if (s < 3) begin
        check($sformatf("ch3_sel%0d.data", s), 32'(data_out3), 32'(chan_val[s]));
        check($sformatf("ch3_sel%0d.valid", s), 32'(valid3), 32'd1);
      end else begin
        check("ch3_oor.data",  32'(data_out3), 32'd0);
        check("ch3_oor.valid", 32'(valid3),    32'd0);
        check("ch3_oor.chan",  32'(chan_out3), 32'd3);
      end
    end

    // dwell = 2: channel k/3 for 3 cycles each, wrap only at k = 12
    mode = 1'b1; dwell = 4'd2;
    for (int k = 0; k <= 18; k++) begin
      step();
      check4($sformatf("scan_d2_k%0d", k), chan_val[(k/3)%4], 2'((k/3)%4), 1'b1,
             k == 12);
    end

    mode = 1'b0; sel = 2'd1;
    step();
    check4("mode_to_manual", 4'hB, 2'd1, 1'b1, 1'b0);

    // dwell = 0: new channel every cycle, restart at 0 without a wrap
    mode = 1'b1; dwell = 4'd0;
    for (int k = 0; k <= 9; k++) begin
      step();
      check4($sformatf("scan_d0_k%0d", k), chan_val[k%4], 2'(k%4), 1'b1,
             (k > 0) && (k % 4 == 0));
    end

    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check4($sformatf("disable%0d", i), 4'hB, 2'd1, 1'b0, 1'b0);
    end

    enable = 1'b1;
    step();
    check4("reenable_scan", 4'hA, 2'd0, 1'b1, 1'b0);
    step();
    check4("reenable_scan_next", 4'hB, 2'd1, 1'b1, 1'b0);

    reset = 1'b1;
    step();
    check4("reset_midscan", 4'h0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check4("post_reset_first", 4'hA, 2'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
